onewire_master_mc: RTL and testbench

//  Multi-channel 1-Wire master: one timing engine shared over OWN open-drain ports, port picked per command.

---
 rtl/onewire_pkg.sv | 61 ++++++
 rtl/onewire_crc8.sv | 34 +++
 rtl/onewire_master_mc.sv | 260 ++++++++++++++++++++++++++
 tb/tb_onewire_master_mc.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared types and tick timing for the multi-channel 1-Wire master.
// Tick constants are in prescaler ticks (5 us normal, 1 us overdrive).
package onewire_pkg;

  typedef enum logic [1:0] {
    OW_RST  = 2'd0,
    OW_WR   = 2'd1,
    OW_RD   = 2'd2,
    OW_RSVD = 2'd3
  } ow_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_HIGH,
    ST_CHK,
    ST_SLOT,
    ST_RCVR,
    ST_DONE
  } ow_state_t;

  localparam int T_RSTL_N = 96;
  localparam int T_RSTL_O = 48;
  localparam int T_RSTH_N = 96;
  localparam int T_RSTH_O = 48;
  localparam int T_PRES_N = 14;
  localparam int T_PRES_O = 10;
  localparam int T_SLOT_N = 12;
  localparam int T_SLOT_O = 6;
  localparam int T_LOW1   = 1;
  localparam int T_SAMP   = 2;
  localparam int T_RCVR_N = 1;
  localparam int T_RCVR_O = 2;

  localparam int TCW = $clog2(T_RSTL_N) + 1;

  typedef logic [TCW-1:0] tick_t;

  typedef struct packed {
    tick_t rstl;
    tick_t rsth;
    tick_t pres;
    tick_t slot;
    tick_t low1;
    tick_t samp;
    tick_t rcvr;
  } ow_timing_t;

  function automatic ow_timing_t ow_timing(input logic ovd);
    ow_timing_t t;
    t.rstl = tick_t'(ovd ? T_RSTL_O : T_RSTL_N);
    t.rsth = tick_t'(ovd ? T_RSTH_O : T_RSTH_N);
    t.pres = tick_t'(ovd ? T_PRES_O : T_PRES_N);
    t.slot = tick_t'(ovd ? T_SLOT_O : T_SLOT_N);
    t.low1 = tick_t'(T_LOW1);
    t.samp = tick_t'(T_SAMP);
    t.rcvr = tick_t'(ovd ? T_RCVR_O : T_RCVR_N);
    return t;
  endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Bit-serial Dallas/Maxim CRC8 (x^8+x^5+x^4+1, reflected), LSB-first input.
// clr has priority over en.
module onewire_crc8 (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    crc_d = crc_q;
    fb    = crc_q[0] ^ din;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = {1'b0, crc_q[7:1]} ^ (fb ? 8'h8C : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    if (!arst_n) crc_q <= 8'h00;
    else         crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/onewire_master_mc.sv
// Multi-channel 1-Wire master: one timing engine shared over OWN open-drain ports.
// Reset/presence, 1..8 bit LSB-first write/read, stuck-low detect, running CRC8.
module onewire_master_mc
  import onewire_pkg::*;
#(
  parameter int OWN   = 4,
  parameter int CDR_N = 49,
  parameter int CDR_O = 9,
  parameter int SYNC  = 1
) (
  input  logic           clk,
  input  logic           arst_n,
  inout  wire  [OWN-1:0] onewire,
  input  logic           cmd_vld,
  output logic           cmd_rdy,
  input  ow_op_t         cmd_op,
  input  logic [3:0]     cmd_port,
  input  logic [2:0]     cmd_len,
  input  logic           cmd_ovd,
  input  logic [7:0]     cmd_wdat,
  input  logic           cmd_crcclr,
  output logic           rsp_vld,
  output logic [7:0]     rsp_dat,
  output logic           rsp_pres,
  output logic           rsp_err,
  output logic [7:0]     crc
);

  localparam int CDR_MAX = (CDR_N > CDR_O) ? CDR_N : CDR_O;
  localparam int PW      = (CDR_MAX > 0) ? $clog2(CDR_MAX + 1) : 1;

  ow_state_t      state_q, state_d;
  ow_op_t         op_q, op_d;
  logic [PW-1:0]  pre_q, pre_d;
  tick_t          tcnt_q, tcnt_d;
  logic [3:0]     bitn_q, bitn_d, port_q, port_d, nbits;
  logic [2:0]     len_q, len_d;
  logic           ovd_q, ovd_d;
  logic [7:0]     wdat_q, wdat_d, dat_q, dat_d;
  logic           pres_q, pres_d, err_q, err_d;
  logic [OWN-1:0] drv_q, drv_d;
  logic           crc_en_q, crc_en_d, crc_din_q, crc_din_d, crc_clr;
  logic           cmd_rdy_q, cmd_rdy_d, rsp_vld_q, rsp_vld_d;
  logic [7:0]     rsp_dat_q, rsp_dat_d;
  logic           rsp_pres_q, rsp_pres_d, rsp_err_q, rsp_err_d;
  logic           tick, line_sel, drive, accept, legal;
  tick_t          low_len;
  ow_timing_t     tm;
  logic [OWN-1:0] line_raw, line_syn;

  assign line_raw = onewire;

  generate
    if (SYNC != 0) begin : g_sync
      logic [OWN-1:0] s1_q, s2_q;
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          s1_q <= '1;
          s2_q <= '1;
        end else begin
          s1_q <= line_raw;
          s2_q <= s1_q;
        end
      end
      assign line_syn = s2_q;
    end else begin : g_direct
      assign line_syn = line_raw;
    end
  endgenerate

  for (genvar i = 0; i < OWN; i++) begin : g_pad
    assign onewire[i] = drv_q[i] ? 1'b0 : 1'bz;
  end

  assign tm     = ow_timing(ovd_q);
  assign tick   = (pre_q == (ovd_q ? PW'(CDR_O) : PW'(CDR_N)));
  assign nbits  = (len_q == 3'd0) ? 4'd8 : {1'b0, len_q};
  assign accept = cmd_vld && cmd_rdy_q;
  assign legal  = (int'(cmd_port) < OWN) && (cmd_op != OW_RSVD);

  always_comb begin
    line_sel = 1'b1;
    for (int i = 0; i < OWN; i++) begin
      if (port_q == 4'(i)) line_sel = line_syn[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_d     = tick ? '0 : pre_q + 1'b1;
    tcnt_d    = tcnt_q;
    bitn_d    = bitn_q;
    op_d      = op_q;
    port_d    = port_q;
    len_d     = len_q;
    ovd_d     = ovd_q;
    wdat_d    = wdat_q;
    dat_d     = dat_q;
    pres_d    = pres_q;
    err_d     = err_q;
    crc_en_d  = 1'b0;
    crc_din_d = 1'b0;
    crc_clr   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          port_d  = cmd_port;
          len_d   = cmd_len;
          ovd_d   = cmd_ovd;
          wdat_d  = cmd_wdat;
          pre_d   = '0;
          tcnt_d  = '0;
          bitn_d  = 4'd0;
          dat_d   = 8'h00;
          pres_d  = 1'b0;
          err_d   = 1'b0;
          crc_clr = cmd_crcclr;
          if (!legal)                state_d = ST_DONE;
          else if (cmd_op == OW_RST) state_d = ST_RST_LOW;
          else                       state_d = ST_CHK;
          err_d = !legal;
        end
      end
      ST_RST_LOW: begin
        if (tick) begin
          if (tcnt_q == tm.rstl - 1'b1) begin
            tcnt_d  = '0;
            state_d = ST_RST_HIGH;
          end else tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_RST_HIGH: begin
        if (tick) begin
          if (tcnt_q == tm.pres - 1'b1) pres_d = ~line_sel;
          if (tcnt_q == tm.rsth - 1'b1) state_d = ST_DONE;
          else                          tcnt_d  = tcnt_q + 1'b1;
        end
      end
      // One clock with the prescaler held, so every slot starts tick-aligned.
      ST_CHK: begin
        pre_d  = '0;
        tcnt_d = '0;
        if (!line_sel) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SLOT;
          if (op_q == OW_WR) begin
            crc_en_d  = 1'b1;
            crc_din_d = wdat_q[bitn_q[2:0]];
          end
        end
      end
      ST_SLOT: begin
        if (tick) begin
          if (op_q == OW_RD && tcnt_q == tm.samp - 1'b1) begin
            dat_d[bitn_q[2:0]] = line_sel;
            crc_en_d           = 1'b1;
            crc_din_d          = line_sel;
          end
          if (tcnt_q == tm.slot - 1'b1) begin
            tcnt_d  = '0;
            state_d = ST_RCVR;
          end else tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_RCVR: begin
        if (tick) begin
          if (tcnt_q == tm.rcvr - 1'b1) begin
            tcnt_d = '0;
            if (bitn_q + 4'd1 == nbits) state_d = ST_DONE;
            else begin
              bitn_d  = bitn_q + 4'd1;
              state_d = ST_CHK;
            end
          end else tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Drive is derived from next-state so the pin changes on the same edge as the FSM.
    low_len = (op_d == OW_WR && !wdat_d[bitn_d[2:0]]) ? tm.slot : tm.low1;
    drive   = (state_d == ST_RST_LOW) || (state_d == ST_SLOT && tcnt_d < low_len);
    for (int i = 0; i < OWN; i++) begin
      drv_d[i] = drive && (port_d == 4'(i));
    end

    cmd_rdy_d  = (state_d == ST_IDLE);
    rsp_vld_d  = (state_q == ST_DONE);
    rsp_dat_d  = rsp_vld_d ? dat_q  : rsp_dat_q;
    rsp_pres_d = rsp_vld_d ? pres_q : rsp_pres_q;
    rsp_err_d  = rsp_vld_d ? err_q  : rsp_err_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OW_RST;
      pre_q      <= '0;
      tcnt_q     <= '0;
      bitn_q     <= 4'd0;
      port_q     <= 4'd0;
      len_q      <= 3'd0;
      ovd_q      <= 1'b0;
      wdat_q     <= 8'h00;
      dat_q      <= 8'h00;
      pres_q     <= 1'b0;
      err_q      <= 1'b0;
      drv_q      <= '0;
      crc_en_q   <= 1'b0;
      crc_din_q  <= 1'b0;
      cmd_rdy_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_dat_q  <= 8'h00;
      rsp_pres_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      pre_q      <= pre_d;
      tcnt_q     <= tcnt_d;
      bitn_q     <= bitn_d;
      port_q     <= port_d;
      len_q      <= len_d;
      ovd_q      <= ovd_d;
      wdat_q     <= wdat_d;
      dat_q      <= dat_d;
      pres_q     <= pres_d;
      err_q      <= err_d;
      drv_q      <= drv_d;
      crc_en_q   <= crc_en_d;
      crc_din_q  <= crc_din_d;
      cmd_rdy_q  <= cmd_rdy_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_dat_q  <= rsp_dat_d;
      rsp_pres_q <= rsp_pres_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  onewire_crc8 u_crc (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (crc_clr),
    .en     (crc_en_q),
    .din    (crc_din_q),
    .crc    (crc)
  );

  assign cmd_rdy  = cmd_rdy_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_dat  = rsp_dat_q;
  assign rsp_pres = rsp_pres_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_onewire_master_mc.sv
// Directed bench for onewire_master_mc at 10 MHz: pulled-up lines plus a
// small slave model on port 2 (presence pulse, read-0 hold, stuck low).
module tb_onewire_master_mc;
  import onewire_pkg::*;

  localparam int OWN = 4;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  wire  [OWN-1:0] ow;
  logic           cmd_vld = 1'b0;
  logic           cmd_rdy;
  ow_op_t         cmd_op = OW_RST;
  logic [3:0]     cmd_port = 4'd0;
  logic [2:0]     cmd_len = 3'd0;
  logic           cmd_ovd = 1'b0;
  logic [7:0]     cmd_wdat = 8'h00;
  logic           cmd_crcclr = 1'b0;
  logic           rsp_vld;
  logic [7:0]     rsp_dat;
  logic           rsp_pres;
  logic           rsp_err;
  logic [7:0]     crc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  onewire_master_mc #(.OWN(OWN), .CDR_N(49), .CDR_O(9), .SYNC(1)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .onewire    (ow),
    .cmd_vld    (cmd_vld),
    .cmd_rdy    (cmd_rdy),
    .cmd_op     (cmd_op),
    .cmd_port   (cmd_port),
    .cmd_len    (cmd_len),
    .cmd_ovd    (cmd_ovd),
    .cmd_wdat   (cmd_wdat),
    .cmd_crcclr (cmd_crcclr),
    .rsp_vld    (rsp_vld),
    .rsp_dat    (rsp_dat),
    .rsp_pres   (rsp_pres),
    .rsp_err    (rsp_err),
    .crc        (crc)
  );

  // Slave model: 0 none, 1 presence responder, 2 read responder
  int   mon_port = 2;
  int   dev_mode = 0;
  logic dev_pull = 1'b0;
  logic stuck = 1'b0;
  int   cyc = 0, fall_t = 0, pres_wait = 0, pres_hold = 0, rd_hold = 0, other_low = 0;
  logic mon_prev = 1'b1, mon_cur;
  int   lows[$];
  int   falls[$];
  bit   rd_q[$];

  for (genvar i = 0; i < OWN; i++) begin : g_line
    pullup (ow[i]);
    assign ow[i] = ((dev_pull || stuck) && mon_port == i) ? 1'b0 : 1'bz;
  end

  always @(negedge clk) begin
    cyc++;
    mon_cur = ow[mon_port];
    for (int i = 0; i < OWN; i++) begin
      if (i != mon_port && ow[i] !== 1'b1) other_low++;
    end
    if (rd_hold > 0) rd_hold--;
    if (pres_wait > 0) begin
      pres_wait--;
      if (pres_wait == 0) pres_hold = 1800;
    end else if (pres_hold > 0) pres_hold--;
    if (mon_prev === 1'b1 && mon_cur === 1'b0) begin
      fall_t = cyc;
      falls.push_back(cyc);
      if (dev_mode == 2 && rd_q.size() > 0) begin
        if (rd_q.pop_front() == 1'b0) rd_hold = 30;
      end
    end
    if (mon_prev === 1'b0 && mon_cur === 1'b1) begin
      lows.push_back(cyc - fall_t);
      if (dev_mode == 1 && (cyc - fall_t) >= 4000) pres_wait = 600;
    end
    dev_pull = (rd_hold > 0) || (pres_hold > 0);
    mon_prev = mon_cur;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input ow_op_t op, input logic [3:0] port, input logic [2:0] len,
                      input logic ovd, input logic [7:0] wdat, input logic crcclr);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_port = port; cmd_len = len; cmd_ovd = ovd;
    cmd_wdat = wdat; cmd_crcclr = crcclr; cmd_vld = 1'b1;
    n = 0;
    while (!cmd_rdy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_rdy, 1'b1);
    @(posedge clk);
    #1 cmd_vld = 1'b0;
    cmd_crcclr = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_vld && lat < budget);
    check("rsp_seen", rsp_vld, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int lat, nvld;
  int exp_low[8] = '{600, 600, 50, 50, 600, 600, 50, 50};
  logic [7:0] rom[7] = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdy", cmd_rdy, 1'b0);
    check("rst_vld", rsp_vld, 1'b0);
    check("rst_dat", rsp_dat, 8'h00);
    check("rst_crc", crc, 8'h00);
    check("rst_line", ow, 4'hF);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rdy_after_rst", cmd_rdy, 1'b1);

    // 1: reset pulse with presence on port 2
    dev_mode = 1; lows.delete();
    send(OW_RST, 4'd2, 3'd0, 1'b0, 8'h00, 1'b0);
    wait_rsp(11000, lat);
    check("t1_pres", rsp_pres, 1'b1);
    check("t1_err", rsp_err, 1'b0);
    check("t1_nlows", lows.size(), 2);
    check("t1_rstl", (lows.size() > 0) ? lows[0] : -1, 4800);
    @(negedge clk);
    check("t1_vld_pulse", rsp_vld, 1'b0);

    // 2: reset pulse, no device; other ports must stay released
    dev_mode = 0; lows.delete(); other_low = 0;
    send(OW_RST, 4'd2, 3'd0, 1'b0, 8'h00, 1'b0);
    wait_rsp(11000, lat);
    check("t2_pres", rsp_pres, 1'b0);
    check("t2_nlows", lows.size(), 1);
    check("t2_others_z", other_low, 0);

    // 3: write 0xCC normal speed
    lows.delete(); falls.delete();
    send(OW_WR, 4'd2, 3'd0, 1'b0, 8'hCC, 1'b1);
    wait_rsp(6000, lat);
    check("t3_err", rsp_err, 1'b0);
    check("t3_nlows", lows.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t3_low%0d", i), (i < lows.size()) ? lows[i] : -1, exp_low[i]);
    for (int i = 1; i < 8; i++)
      check($sformatf("t3_period%0d", i), (i < falls.size()) ? falls[i] - falls[i-1] : -1, 651);

    // 4: read 4 bits overdrive, slave returns 1,0,1,1
    dev_mode = 2; lows.delete();
    rd_q.delete(); rd_q.push_back(1'b1); rd_q.push_back(1'b0); rd_q.push_back(1'b1); rd_q.push_back(1'b1);
    send(OW_RD, 4'd2, 3'd4, 1'b1, 8'h00, 1'b0);
    wait_rsp(1000, lat);
    check("t4_dat", rsp_dat, 8'h0D);
    check("t4_err", rsp_err, 1'b0);
    check("t4_slots", rd_q.size(), 0);
    check("t4_low1_b0", (lows.size() > 0) ? lows[0] : -1, 10);
    check("t4_low1_b2", (lows.size() > 2) ? lows[2] : -1, 10);

    // 5: CRC over a ROM image, overdrive writes
    dev_mode = 0;
    for (int i = 0; i < 7; i++) begin
      send(OW_WR, 4'd2, 3'd0, 1'b1, rom[i], (i == 0));
      wait_rsp(1000, lat);
    end
    check("t5_crc_rom", crc, 8'hA2);
    send(OW_RST, 4'd2, 3'd0, 1'b1, 8'h00, 1'b0);
    wait_rsp(2000, lat);
    check("t5_crc_after_rst", crc, 8'hA2);
    send(OW_WR, 4'd2, 3'd0, 1'b1, 8'hA2, 1'b0);
    wait_rsp(1000, lat);
    check("t5_crc_zero", crc, 8'h00);

    // 6a: line stuck low -> error on first bit, CRC untouched
    stuck = 1'b1;
    repeat (5) @(negedge clk);
    send(OW_WR, 4'd2, 3'd0, 1'b0, 8'hFF, 1'b0);
    wait_rsp(50, lat);
    check("t6_stuck_err", rsp_err, 1'b1);
    check("t6_stuck_lat", lat, 3);
    check("t6_stuck_crc", crc, 8'h00);
    stuck = 1'b0;
    repeat (5) @(negedge clk);

    // 6b: bad port and reserved op, 2 cycles to response, ready alongside
    send(OW_WR, 4'd7, 3'd0, 1'b0, 8'h55, 1'b0);
    wait_rsp(50, lat);
    check("t6_port_err", rsp_err, 1'b1);
    check("t6_port_lat", lat, 2);
    check("t6_rdy_with_vld", cmd_rdy, 1'b1);
    send(ow_op_t'(2'd3), 4'd2, 3'd0, 1'b0, 8'h55, 1'b0);
    wait_rsp(50, lat);
    check("t6_op_err", rsp_err, 1'b1);
    check("t6_op_lat", lat, 2);
    send(OW_WR, 4'd2, 3'd1, 1'b1, 8'h01, 1'b0);
    wait_rsp(200, lat);
    check("t6_ok_err_clr", rsp_err, 1'b0);

    // 6c: reset mid-slot releases the line, no response follows
    send(OW_WR, 4'd2, 3'd0, 1'b0, 8'h00, 1'b0);
    repeat (200) @(negedge clk);
    check("t6_mid_low", ow[2], 1'b0);
    #1 arst_n = 1'b0;
    #1;
    check("t6_arst_line", ow[2], 1'b1);
    check("t6_arst_rdy", cmd_rdy, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
    nvld = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rsp_vld) nvld++;
    end
    check("t6_no_rsp", nvld, 0);
    check("t6_rdy_back", cmd_rdy, 1'b1);
    check("t6_others_z_all", other_low, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
